// File: rtl/range_counter.sv
// Bounded up/down counter with wrap or saturate behaviour at its limits.
// Optional prescaler: define RANGE_COUNTER_PRESCALE_EN.
module range_counter #(
   parameter int WIDTH     = 16,
   parameter int STEP      = 1,
   parameter int PRE_WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_up,
   input  logic             i_sat,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic [WIDTH-1:0] i_bottom,
   input  logic [WIDTH-1:0] i_top,
`ifdef RANGE_COUNTER_PRESCALE_EN
   input  logic [PRE_WIDTH-1:0] i_prescale,
`endif
   output logic [WIDTH-1:0] o_value,
   output logic             o_wrap,
   output logic             o_at_limit,
   output logic             o_err
);

   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] value_q, value_d;
   logic             wrap_q, wrap_d;
   logic             tick;
   logic             count_ev;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   down_floor;

   assign o_err      = i_bottom > i_top;
   assign o_value    = value_q;
   assign o_wrap     = wrap_q;
   assign o_at_limit = i_up ? (value_q >= i_top) : (value_q <= i_bottom);
   assign count_ev   = i_enable && tick && !o_err;

`ifdef RANGE_COUNTER_PRESCALE_EN
   logic [PRE_WIDTH-1:0] pre_q, pre_d;

   assign tick = (pre_q == i_prescale);

   always_comb begin
      pre_d = pre_q;
      if (i_load) begin
         pre_d = '0;
      end else if (i_enable && !o_err) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Extra bit keeps the limit compares free of modular rollover.
   assign up_sum     = {1'b0, value_q} + STEP_W;
   assign down_floor = {1'b0, i_bottom} + STEP_W;

   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      if (i_load) begin
         value_d = i_load_value;
      end else if (count_ev) begin
         if (i_up) begin
            if (up_sum <= {1'b0, i_top}) begin
               value_d = up_sum[WIDTH-1:0];
            end else if (i_sat) begin
               value_d = i_top;
            end else begin
               value_d = i_bottom;
               wrap_d  = 1'b1;
            end
         end else begin
            if ({1'b0, value_q} >= down_floor) begin
               value_d = value_q - STEP_W[WIDTH-1:0];
            end else if (i_sat) begin
               value_d = i_bottom;
            end else begin
               value_d = i_top;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         value_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
      end
   end

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: two instances (STEP=1, STEP=3)
// checked against an integer reference model of the counting rules.
module tb_range_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       up = 1'b1;
   logic       sat = 1'b0;
   logic       load = 1'b0;
   logic [7:0] lv = '0;
   logic [7:0] bot = '0;
   logic [7:0] top = '0;

   logic [7:0] v1, v3;
   logic       w1, w3, a1, a3, e1, e3;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int v1;
      int v3;
      bit w1;
      bit w3;
      bit a1;
      bit a3;
      bit e;
   } exp_t;

   exp_t q[$];
   int   m1, m3;
   bit   done = 1'b0;

   always #5 clk = ~clk;

   range_counter #(.WIDTH(8), .STEP(1)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up),
      .i_sat(sat), .i_load(load), .i_load_value(lv),
      .i_bottom(bot), .i_top(top),
`ifdef RANGE_COUNTER_PRESCALE_EN
      .i_prescale(8'd0),
`endif
      .o_value(v1), .o_wrap(w1), .o_at_limit(a1), .o_err(e1)
   );

   range_counter #(.WIDTH(8), .STEP(3)) dut3 (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_up(up),
      .i_sat(sat), .i_load(load), .i_load_value(lv),
      .i_bottom(bot), .i_top(top),
`ifdef RANGE_COUNTER_PRESCALE_EN
      .i_prescale(8'd0),
`endif
      .o_value(v3), .o_wrap(w3), .o_at_limit(a3), .o_err(e3)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d",
                  name, $time, act, exp);
      end
   endtask

   function automatic void model(inout int v, output bit w,
                                 input int step);
      int b, t;
      b = bot;
      t = top;
      w = 1'b0;
      if (reset) begin
         v = 0;
      end else if (load) begin
         v = lv;
      end else if (enable && !(b > t)) begin
         if (up) begin
            if (v + step <= t) v = v + step;
            else if (sat) v = t;
            else begin v = b; w = 1'b1; end
         end else begin
            if (v >= b + step) v = v - step;
            else if (sat) v = b;
            else begin v = t; w = 1'b1; end
         end
      end
   endfunction

   task automatic cyc(input bit r, input bit en, input bit u,
                      input bit s, input bit ld, input int lvv,
                      input int b, input int t);
      exp_t e;
      bit   wa, wb;
      @(negedge clk);
      reset  = r;
      enable = en;
      up     = u;
      sat    = s;
      load   = ld;
      lv     = 8'(lvv);
      bot    = 8'(b);
      top    = 8'(t);
      model(m1, wa, 1);
      model(m3, wb, 3);
      e.v1 = m1;
      e.v3 = m3;
      e.w1 = wa;
      e.w3 = wb;
      e.a1 = u ? (m1 >= t) : (m1 <= b);
      e.a3 = u ? (m3 >= t) : (m3 <= b);
      e.e  = b > t;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("value_s1", v1, e.v1);
            chk("wrap_s1", w1, e.w1);
            chk("limit_s1", a1, e.a1);
            chk("err_s1", e1, e.e);
            chk("value_s3", v3, e.v3);
            chk("wrap_s3", w3, e.w3);
            chk("limit_s3", a3, e.a3);
            chk("err_s3", e3, e.e);
         end
      end
   end

   initial begin : stim
      int b, t;
      m1 = 0;
      m3 = 0;
      cyc(1, 0, 1, 0, 0, 0, 0, 9);
      cyc(1, 1, 1, 0, 1, 7, 0, 9);
      // 0..9 wrap sequence
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0, 0, 9);
      // load out of range then saturate down to bottom
      cyc(0, 1, 0, 1, 1, 250, 10, 200);
      for (int i = 0; i < 250; i++) cyc(0, 1, 0, 1, 0, 0, 10, 200);
      // STEP=3 boundary from 9 with top 10
      cyc(0, 0, 1, 0, 1, 9, 2, 10);
      cyc(0, 1, 1, 0, 0, 0, 2, 10);
      cyc(0, 0, 1, 1, 1, 9, 2, 10);
      cyc(0, 1, 1, 1, 0, 0, 2, 10);
      // top of the value space, no rollover
      cyc(0, 0, 1, 0, 1, 255, 0, 255);
      cyc(0, 1, 1, 0, 0, 0, 0, 255);
      cyc(0, 0, 1, 1, 1, 254, 0, 255);
      cyc(0, 1, 1, 1, 0, 0, 0, 255);
      // equal bounds
      for (int i = 0; i < 4; i++) cyc(0, 1, i % 2, 0, 0, 0, 6, 6);
      // error freeze and resume
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 5, 4);
      cyc(0, 1, 1, 0, 1, 3, 5, 4);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 5, 8);
      // reset vs load priority
      cyc(0, 0, 1, 0, 1, 7, 0, 20);
      cyc(1, 1, 1, 0, 1, 7, 0, 20);
      cyc(0, 1, 1, 0, 1, 15, 0, 20);
      cyc(0, 1, 1, 0, 0, 0, 0, 20);
      b = 0;
      t = 20;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            b = $urandom_range(0, 255);
            t = b + $urandom_range(0, 24);
            if (t > 255) t = 255;
            if ($urandom_range(0, 7) == 0) t = $urandom_range(0, 255);
         end
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 19) == 0, $urandom_range(0, 255), b, t);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
